// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle RISC-V controller: states, opcodes and
// datapath mux/ALU select codes.
package multicycle_control_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned SEL_W    = 2;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_e;

    localparam logic [OPCODE_W-1:0] OP_LOAD  = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_RTYPE = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_ITYPE = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_JAL   = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 7'b1100011;

    localparam logic [SEL_W-1:0] IMM_I = 2'b00;
    localparam logic [SEL_W-1:0] IMM_S = 2'b01;
    localparam logic [SEL_W-1:0] IMM_B = 2'b10;
    localparam logic [SEL_W-1:0] IMM_J = 2'b11;

    localparam logic [SEL_W-1:0] ALU_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALU_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALU_FUNCT = 2'b10;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

    localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
    localparam logic [SEL_W-1:0] RES_MEMDATA   = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

    localparam logic ADR_PC  = 1'b0;
    localparam logic ADR_ALU = 1'b1;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory bundle; master is the controller side.
interface multicycle_control_if;
    import multicycle_control_pkg::*;

    logic [OPCODE_W-1:0] opcode;
    logic                zero;
    logic                mem_ready;

    logic                mem_req;
    logic                mem_write;
    logic                ir_write;
    logic                pc_write;
    logic                adr_src;
    logic [SEL_W-1:0]    alu_src_a;
    logic [SEL_W-1:0]    alu_src_b;
    logic [SEL_W-1:0]    alu_op;
    logic [SEL_W-1:0]    result_src;
    logic                reg_write;
    logic [SEL_W-1:0]    imm_src;
    logic                illegal;
    logic [STATE_W-1:0]  state;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, mem_write, ir_write, pc_write, adr_src, alu_src_a,
               alu_src_b, alu_op, result_src, reg_write, imm_src, illegal, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, mem_write, ir_write, pc_write, adr_src, alu_src_a,
               alu_src_b, alu_op, result_src, reg_write, imm_src, illegal, state
    );

endinterface

// File: rtl/multicycle_control.sv
// Multicycle RISC-V main controller: state register plus a Moore decode of
// datapath controls; only pc_write, ir_write and illegal look at inputs.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    state_e state_q, state_d;
    logic   is_store_q, is_store_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            is_store_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
        end
    end

    // Load/store flavour is latched in DECODE so MEMADR decodes from state only.
    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        case (state_q)
            S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LOAD:  begin state_d = S_MEMADR; is_store_d = 1'b0; end
                    OP_STORE: begin state_d = S_MEMADR; is_store_d = 1'b1; end
                    OP_RTYPE: state_d = S_EXECR;
                    OP_ITYPE: state_d = S_EXECI;
                    OP_JAL:   state_d = S_JAL;
                    OP_BEQ:   state_d = S_BEQ;
                    default:  state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = is_store_q ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (bus.mem_ready) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_BEQ:      state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    logic             mem_req, mem_write, ir_write, pc_write, adr_src;
    logic             reg_write, illegal;
    logic [SEL_W-1:0] alu_src_a, alu_src_b, alu_op, result_src, imm_src;

    // Output decode; everything is held low while reset is asserted.
    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        adr_src    = ADR_PC;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALU_ADD;
        result_src = RES_ALUOUT;
        reg_write  = 1'b0;
        imm_src    = IMM_I;
        illegal    = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    ir_write   = bus.mem_ready;
                    pc_write   = bus.mem_ready;
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALURESULT;
                end
                S_DECODE: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                    imm_src   = IMM_B;
                    illegal   = !(bus.opcode inside {OP_LOAD, OP_STORE, OP_RTYPE,
                                                     OP_ITYPE, OP_JAL, OP_BEQ});
                end
                S_MEMADR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    imm_src   = is_store_q ? IMM_S : IMM_I;
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = ADR_ALU;
                end
                S_MEMWB: begin
                    result_src = RES_MEMDATA;
                    reg_write  = 1'b1;
                end
                S_MEMWRITE: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    adr_src   = ADR_ALU;
                end
                S_EXECR: begin
                    alu_src_a = SRCA_RS1;
                    alu_op    = ALU_FUNCT;
                end
                S_EXECI: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALU_FUNCT;
                end
                S_ALUWB: reg_write = 1'b1;
                S_JAL: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_FOUR;
                    imm_src   = IMM_J;
                    pc_write  = 1'b1;
                    reg_write = 1'b1;
                end
                S_BEQ: begin
                    alu_src_a = SRCA_RS1;
                    alu_op    = ALU_SUB;
                    imm_src   = IMM_B;
                    pc_write  = bus.zero;
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_req    = mem_req;
    assign bus.mem_write  = mem_write;
    assign bus.ir_write   = ir_write;
    assign bus.pc_write   = pc_write;
    assign bus.adr_src    = adr_src;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.alu_op     = alu_op;
    assign bus.result_src = result_src;
    assign bus.reg_write  = reg_write;
    assign bus.imm_src    = imm_src;
    assign bus.illegal    = illegal;
    assign bus.state      = reset ? '0 : STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed scenarios then random instruction
// streams, each cycle checked against a per-instruction expected trace.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    multicycle_control_if bus();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Expected control word for one cycle, straight from the per-state table.
    function automatic logic [20:0] model_out(state_e s, logic mr, logic z,
                                              logic [6:0] op, logic rst);
        logic       m_req, m_wr, irw, pcw, adr, rw, ill;
        logic [1:0] sa, sb, aop, res, imm;
        logic [3:0] st;
        m_req = 0; m_wr = 0; irw = 0; pcw = 0; adr = 0; rw = 0; ill = 0;
        sa = 0; sb = 0; aop = 0; res = 0; imm = 0; st = 4'(s);
        if (rst) st = 4'd0;
        else begin
            case (s)
                S_FETCH:    begin m_req = 1; irw = mr; pcw = mr; sa = 2'b00; sb = 2'b10;
                                  aop = 2'b00; res = 2'b10; end
                S_DECODE:   begin sa = 2'b01; sb = 2'b01; imm = 2'b10;
                                  ill = !(op inside {7'b0000011, 7'b0100011, 7'b0110011,
                                                     7'b0010011, 7'b1101111, 7'b1100011}); end
                S_MEMADR:   begin sa = 2'b10; sb = 2'b01;
                                  imm = (op == 7'b0100011) ? 2'b01 : 2'b00; end
                S_MEMREAD:  begin m_req = 1; adr = 1; end
                S_MEMWB:    begin res = 2'b01; rw = 1; end
                S_MEMWRITE: begin m_req = 1; m_wr = 1; adr = 1; end
                S_EXECR:    begin sa = 2'b10; sb = 2'b00; aop = 2'b10; end
                S_EXECI:    begin sa = 2'b10; sb = 2'b01; aop = 2'b10; imm = 2'b00; end
                S_ALUWB:    begin res = 2'b00; rw = 1; end
                S_JAL:      begin sa = 2'b01; sb = 2'b10; res = 2'b00; imm = 2'b11;
                                  pcw = 1; rw = 1; end
                S_BEQ:      begin sa = 2'b10; sb = 2'b00; aop = 2'b01; imm = 2'b10; pcw = z; end
                default: ;
            endcase
        end
        return {st, m_req, m_wr, irw, pcw, adr, sa, sb, aop, res, rw, imm, ill};
    endfunction

    task automatic cycle(input state_e es, input logic mr, input logic z,
                         input logic [6:0] op, input logic rst);
        logic [20:0] exp, got;
        string       tag;
        reset = rst; bus.mem_ready = mr; bus.zero = z; bus.opcode = op;
        #1;
        exp = model_out(es, mr, z, op, rst);
        got = {bus.state, bus.mem_req, bus.mem_write, bus.ir_write, bus.pc_write,
               bus.adr_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.result_src,
               bus.reg_write, bus.imm_src, bus.illegal};
        tag = rst ? "RESET" : es.name();
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s op=%b mr=%b z=%b: observed=%h expected=%h",
                   tag, op, mr, z, got, exp);
        end
        @(negedge clk);
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // One instruction from FETCH onward; stall counts are drawn by the caller.
    task automatic run_instr(input logic [6:0] op, input int fstall,
                             input int mstall, input logic z);
        for (int i = 0; i < fstall; i++) cycle(S_FETCH, 1'b0, rb(), 7'($urandom), 1'b0);
        cycle(S_FETCH, 1'b1, rb(), 7'($urandom), 1'b0);
        cycle(S_DECODE, rb(), rb(), op, 1'b0);
        case (op)
            OP_LOAD: begin
                cycle(S_MEMADR, rb(), rb(), op, 1'b0);
                for (int i = 0; i < mstall; i++) cycle(S_MEMREAD, 1'b0, rb(), op, 1'b0);
                cycle(S_MEMREAD, 1'b1, rb(), op, 1'b0);
                cycle(S_MEMWB, rb(), rb(), op, 1'b0);
            end
            OP_STORE: begin
                cycle(S_MEMADR, rb(), rb(), op, 1'b0);
                for (int i = 0; i < mstall; i++) cycle(S_MEMWRITE, 1'b0, rb(), op, 1'b0);
                cycle(S_MEMWRITE, 1'b1, rb(), op, 1'b0);
            end
            OP_RTYPE: begin cycle(S_EXECR, rb(), rb(), op, 1'b0); cycle(S_ALUWB, rb(), rb(), op, 1'b0); end
            OP_ITYPE: begin cycle(S_EXECI, rb(), rb(), op, 1'b0); cycle(S_ALUWB, rb(), rb(), op, 1'b0); end
            OP_JAL:   begin cycle(S_JAL, rb(), rb(), op, 1'b0); cycle(S_ALUWB, rb(), rb(), op, 1'b0); end
            OP_BEQ:   cycle(S_BEQ, rb(), z, op, 1'b0);
            default: ;
        endcase
    endtask

    initial begin
        reset = 1'b1; bus.mem_ready = 1'b0; bus.zero = 1'b0; bus.opcode = '0;
        @(negedge clk);
        cycle(S_FETCH, 1'b1, 1'b0, 7'b0, 1'b1);
        cycle(S_FETCH, 1'b0, 1'b1, 7'b0, 1'b1);

        run_instr(OP_LOAD, 0, 0, 1'b0);
        run_instr(OP_BEQ, 0, 0, 1'b1);
        run_instr(OP_BEQ, 0, 0, 1'b0);
        run_instr(OP_RTYPE, 3, 0, 1'b0);
        run_instr(7'b1111111, 0, 0, 1'b0);
        run_instr(OP_JAL, 0, 0, 1'b0);
        run_instr(OP_ITYPE, 0, 0, 1'b0);
        run_instr(OP_STORE, 0, 2, 1'b0);

        // Reset while a store is stalled in MEMWRITE.
        cycle(S_FETCH, 1'b1, 1'b0, 7'b0, 1'b0);
        cycle(S_DECODE, 1'b1, 1'b0, OP_STORE, 1'b0);
        cycle(S_MEMADR, 1'b0, 1'b0, OP_STORE, 1'b0);
        cycle(S_MEMWRITE, 1'b0, 1'b0, OP_STORE, 1'b0);
        cycle(S_MEMWRITE, 1'b0, 1'b0, OP_STORE, 1'b1);
        cycle(S_FETCH, 1'b0, 1'b0, OP_STORE, 1'b0);

        // Reset during a fetch stall and again mid-load.
        cycle(S_FETCH, 1'b0, 1'b0, 7'b0, 1'b1);
        cycle(S_FETCH, 1'b1, 1'b0, OP_LOAD, 1'b0);
        cycle(S_DECODE, 1'b1, 1'b0, OP_LOAD, 1'b0);
        cycle(S_MEMADR, 1'b1, 1'b0, OP_LOAD, 1'b1);
        run_instr(OP_LOAD, 1, 1, 1'b0);

        for (int n = 0; n < 300; n++) begin
            logic [6:0] op;
            case ($urandom_range(0, 6))
                0: op = OP_LOAD;
                1: op = OP_STORE;
                2: op = OP_RTYPE;
                3: op = OP_ITYPE;
                4: op = OP_JAL;
                5: op = OP_BEQ;
                default: op = 7'($urandom);
            endcase
            run_instr(op, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                      ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0, rb());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
